// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage
module ex_div #(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {
      ST_FREE    = 2'd0,
      ST_BY_ZERO = 2'd1,
      ST_ON      = 2'd2,
      ST_END     = 2'd3
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [DATA_W-1:0]   dvd;
   logic [DATA_W-1:0]   dvs;
   logic [DATA_W-1:0]   rem;
   logic [DATA_W-1:0]   quo;
   logic                sign1;
   logic                sign2;
   logic                sgn;

   logic [DATA_W:0]     shifted;
   logic [DATA_W:0]     trial;
   logic [DATA_W-1:0]   abs1;
   logic [DATA_W-1:0]   abs2;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;

   // rem is always below the divisor, so a negative trial shows up in the top bit
   assign shifted = {rem, dvd[DATA_W-1]};
   assign trial   = shifted - {1'b0, dvs};

   assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? ({DATA_W{1'b0}} - opdata1_i) : opdata1_i;
   assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? ({DATA_W{1'b0}} - opdata2_i) : opdata2_i;

   // Remainder follows the dividend sign; the most-negative / -1 case wraps naturally
   assign quo_fix = (sgn && (sign1 ^ sign2)) ? ({DATA_W{1'b0}} - quo) : quo;
   assign rem_fix = (sgn && sign1) ? ({DATA_W{1'b0}} - rem) : rem;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_FREE;
         cnt      <= '0;
         dvd      <= '0;
         dvs      <= '0;
         rem      <= '0;
         quo      <= '0;
         sign1    <= 1'b0;
         sign2    <= 1'b0;
         sgn      <= 1'b0;
         ready_o  <= 1'b0;
         result_o <= '0;
      end else begin
         case (state)
            ST_FREE: begin
               ready_o  <= 1'b0;
               result_o <= '0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state <= ST_BY_ZERO;
                  end else begin
                     state <= ST_ON;
                     dvd   <= abs1;
                     dvs   <= abs2;
                     sign1 <= signed_div_i & opdata1_i[DATA_W-1];
                     sign2 <= signed_div_i & opdata2_i[DATA_W-1];
                     sgn   <= signed_div_i;
                     cnt   <= '0;
                     rem   <= '0;
                     quo   <= '0;
                  end
               end
            end
            ST_BY_ZERO: begin
               state    <= ST_END;
               ready_o  <= 1'b1;
               result_o <= '0;
            end
            ST_ON: begin
               if (annul_i) begin
                  state    <= ST_FREE;
                  cnt      <= '0;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end else if (cnt == CNT_W'(DATA_W)) begin
                  state    <= ST_END;
                  ready_o  <= 1'b1;
                  result_o <= {rem_fix, quo_fix};
               end else begin
                  rem <= trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
                  quo <= {quo[DATA_W-2:0], ~trial[DATA_W]};
                  dvd <= {dvd[DATA_W-2:0], 1'b0};
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_END: begin
               if (!start_i) begin
                  state    <= ST_FREE;
                  ready_o  <= 1'b0;
                  result_o <= '0;
               end
            end
            default: state <= ST_FREE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - directed and random checks of ex_div with an expected-result queue
module tb_ex_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;

   logic [63:0] exp_q[$];
   int          n_assert = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   ex_div #(.DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (opdata1),
      .opdata2_i    (opdata2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [63:0] e);
      signed_div = s;
      opdata1    = a;
      opdata2    = b;
      start      = 1'b1;
      if (push) exp_q.push_back(e);
   endtask

   // Entered just after the edge that accepted start (E0)
   task automatic wait_done(input string tag, input int lat);
      int          n = 0;
      bit          seen = 0;
      logic [63:0] e;
      opdata1    = $urandom;
      opdata2    = $urandom;
      signed_div = 1'($urandom);
      while (!seen && n < 40) begin
         tick();
         n++;
         if (ready) seen = 1;
      end
      check({tag, " latency"}, 64'(n), 64'(lat));
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      check({tag, " result"}, result, e);
      annul = 1'b1;
      tick();
      annul = 1'b0;
      check({tag, " hold ready"}, 64'(ready), 64'd1);
      check({tag, " hold result"}, result, e);
      start = 1'b0;
      tick();
      check({tag, " release ready"}, 64'(ready), 64'd0);
      check({tag, " release result"}, result, 64'd0);
   endtask

   task automatic div(input string tag, input bit s, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] e);
      issue(s, a, b, 1'b1, e);
      tick();
      wait_done(tag, (b == 32'd0) ? 1 : 33);
   endtask

   initial begin
      logic [31:0] ra, rb;
      bit          rs;

      rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
      opdata1 = '0; opdata2 = '0;
      tick();
      tick();
      check("reset ready", 64'(ready), 64'd0);
      check("reset result", result, 64'd0);
      rst = 1'b0;
      tick();

      div("divu 100/7",  1'b0, 32'd100,       32'd7,         {32'd2, 32'd14});
      div("div -7/2",    1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF, 32'hFFFFFFFD});
      div("div 7/-2",    1'b1, 32'd7,         32'hFFFFFFFE,  {32'h00000001, 32'hFFFFFFFD});
      div("divu max/1",  1'b0, 32'hFFFFFFFF,  32'd1,         {32'd0, 32'hFFFFFFFF});
      div("div min/-1",  1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'd0, 32'h80000000});
      div("divu 5/0",    1'b0, 32'd5,         32'd0,         64'd0);
      div("div -1/0",    1'b1, 32'hFFFFFFFF,  32'd0,         64'd0);
      div("divu 3/10",   1'b0, 32'd3,         32'd10,        {32'd3, 32'd0});

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 28);
         if (rb == 32'd0) rb = 32'd3;
         rs = 1'(i);
         div("random", rs, ra, rb, model(rs, ra, rb));
      end

      // Annul at E10 of ON, restart at E12
      issue(1'b0, 32'd1000, 32'd3, 1'b0, 64'd0);
      tick();
      for (int i = 1; i <= 9; i++) begin
         tick();
         check("busy ready low", 64'(ready), 64'd0);
      end
      annul = 1'b1;
      tick();
      annul = 1'b0;
      start = 1'b0;
      tick();
      check("annul ready low", 64'(ready), 64'd0);
      check("annul result zero", result, 64'd0);
      div("post annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});

      // Reset at E20 of ON with start held through reset
      issue(1'b1, 32'h12345678, 32'd9, 1'b0, 64'd0);
      tick();
      for (int i = 1; i <= 19; i++) tick();
      rst = 1'b1;
      issue(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2});
      tick();
      check("mid reset ready", 64'(ready), 64'd0);
      check("mid reset result", result, 64'd0);
      rst = 1'b0;
      tick();
      wait_done("post reset", 33);

      check("queue drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
